cdr_shift_controller: RTL and testbench

Phase-decision sequencer for the PRN-based CDR delay line. It integrates early/late votes from the bang-bang phase detector and issues single-cycle `shift_left`/`shift_right` commands to `delay_line_controller`. Commands are rate-limited, and the block tracks the delay-line tap position so a shift is never commanded past either end of the line. It also flags loop lock once phase corrections stop.

---
 rtl/cdr_shift_controller.sv | 153 +++++++++++++++
 tb/tb_cdr_shift_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdr_shift_controller.sv
// cdr_shift_controller: integrates bang-bang PD early/late votes and issues
// rate-limited single-cycle tap shift commands to the delay-line controller.
// Tracks the tap index so the line is never driven past either end, and
// raises a lock flag once corrections have stopped for LOCK_CNT cycles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | loop disabled; counters and lock cleared, tap index held
// ACCUM | integrating votes toward +/-THRESH
// HOLD  | settling after a shift; votes ignored for HOLDOFF cycles
module cdr_shift_controller #(
   parameter int THRESH   = 8,
   parameter int CNT_W    = 5,
   parameter int HOLDOFF  = 4,
   parameter int TAPS     = 16,
   parameter int INIT_TAP = 8,
   parameter int LOCK_CNT = 64,
   localparam int TAP_W   = $clog2(TAPS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             early_i,
   input  logic             late_i,
   output logic             shift_left_o,
   output logic             shift_right_o,
   output logic [TAP_W-1:0] tap_sel_o,
   output logic             at_min_o,
   output logic             at_max_o,
   output logic             locked_o
);

   localparam int HOLD_W = $clog2(HOLDOFF + 1);
   localparam int LOCK_W = $clog2(LOCK_CNT + 1);

   localparam logic signed [CNT_W-1:0] THR_P  = CNT_W'(THRESH);
   localparam logic signed [CNT_W-1:0] THR_N  = -THR_P;
   localparam logic signed [CNT_W-1:0] V_ONE  = CNT_W'(1);
   localparam logic signed [CNT_W-1:0] V_MONE = -V_ONE;
   localparam logic [TAP_W-1:0]  TAP_MAX  = TAP_W'(TAPS - 1);
   localparam logic [TAP_W-1:0]  TAP_INIT = TAP_W'(INIT_TAP);
   localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLDOFF - 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                   state_q;
   logic signed [CNT_W-1:0]  cnt_q;
   logic [HOLD_W-1:0]        hold_q;
   logic [LOCK_W-1:0]        quiet_q;
   logic [TAP_W-1:0]         tap_q;
   logic                     shift_left_q;
   logic                     shift_right_q;
   logic                     locked_q;

   logic signed [CNT_W-1:0]  vote_d;
   logic signed [CNT_W-1:0]  cnt_d;
   logic [LOCK_W-1:0]        quiet_d;
   logic                     tap_min;
   logic                     tap_max;

   assign tap_min = (tap_q == '0);
   assign tap_max = (tap_q == TAP_MAX);

   // Vote decode, next vote count and saturating quiet-count increment.
   always_comb begin
      vote_d = '0;
      if (early_i && !late_i) begin
         vote_d = V_ONE;
      end else if (late_i && !early_i) begin
         vote_d = V_MONE;
      end
      cnt_d   = cnt_q + vote_d;
      quiet_d = (quiet_q == LOCK_MAX) ? quiet_q : quiet_q + LOCK_W'(1);
   end

   // Sequencer: state, counters, tap tracking and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         hold_q        <= '0;
         quiet_q       <= '0;
         tap_q         <= TAP_INIT;
         shift_left_q  <= 1'b0;
         shift_right_q <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         shift_left_q  <= 1'b0;
         shift_right_q <= 1'b0;
         if (!en_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            quiet_q  <= '0;
            locked_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= ACCUM;
               end
               ACCUM: begin
                  if (cnt_d == THR_P && !tap_max) begin
                     shift_left_q <= 1'b1;
                     tap_q        <= tap_q + TAP_W'(1);
                     cnt_q        <= '0;
                     hold_q       <= HOLD_LD;
                     quiet_q      <= '0;
                     locked_q     <= 1'b0;
                     state_q      <= HOLD;
                  end else if (cnt_d == THR_N && !tap_min) begin
                     shift_right_q <= 1'b1;
                     tap_q         <= tap_q - TAP_W'(1);
                     cnt_q         <= '0;
                     hold_q        <= HOLD_LD;
                     quiet_q       <= '0;
                     locked_q      <= 1'b0;
                     state_q       <= HOLD;
                  end else begin
                     // A threshold hit at the end stop is simply dropped.
                     cnt_q    <= (cnt_d == THR_P || cnt_d == THR_N) ? '0 : cnt_d;
                     quiet_q  <= quiet_d;
                     locked_q <= (quiet_d == LOCK_MAX);
                  end
               end
               HOLD: begin
                  cnt_q <= '0;
                  if (hold_q == '0) begin
                     state_q <= ACCUM;
                  end else begin
                     hold_q <= hold_q - HOLD_W'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign shift_left_o  = shift_left_q;
   assign shift_right_o = shift_right_q;
   assign tap_sel_o     = tap_q;
   assign at_min_o      = tap_min;
   assign at_max_o      = tap_max;
   assign locked_o      = locked_q;

endmodule

// File: tb/tb_cdr_shift_controller.sv
// Bench for cdr_shift_controller: a cycle-level reference model pushes the
// expected outputs for each driven cycle onto a queue; they are popped and
// compared after the clock edge. Directed checks mark the scenario milestones.
module tb_cdr_shift_controller;

   localparam int THRESH   = 8;
   localparam int HOLDOFF  = 4;
   localparam int TAPS     = 16;
   localparam int INIT_TAP = 8;
   localparam int LOCK_CNT = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       early = 1'b0;
   logic       late = 1'b0;
   logic       sl;
   logic       sr;
   logic [3:0] tap;
   logic       amin;
   logic       amax;
   logic       lck;

   always #5 clk = ~clk;

   cdr_shift_controller #(
      .THRESH   (THRESH),
      .CNT_W    (5),
      .HOLDOFF  (HOLDOFF),
      .TAPS     (TAPS),
      .INIT_TAP (INIT_TAP),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .en_i          (en),
      .early_i       (early),
      .late_i        (late),
      .shift_left_o  (sl),
      .shift_right_o (sr),
      .tap_sel_o     (tap),
      .at_min_o      (amin),
      .at_max_o      (amax),
      .locked_o      (lck)
   );

   int errors = 0;
   int checks = 0;
   int n_sl   = 0;
   int n_sr   = 0;
   logic [8:0] sbq[$];

   // reference model state: mode 0 idle, 1 accumulate, 2 settling
   int m_mode, m_cnt, m_wait, m_quiet, m_tap;
   bit m_sl, m_sr, m_lock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function void model_reset();
      m_mode = 0; m_cnt = 0; m_wait = 0; m_quiet = 0; m_tap = INIT_TAP;
      m_sl = 0; m_sr = 0; m_lock = 0;
   endfunction

   function void model_edge(bit e_en, bit e_early, bit e_late);
      int v;
      int n;
      v = (e_early && !e_late) ? 1 : ((e_late && !e_early) ? -1 : 0);
      m_sl = 0;
      m_sr = 0;
      if (!e_en) begin
         m_mode = 0; m_cnt = 0; m_wait = 0; m_quiet = 0; m_lock = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         m_wait++;
         if (m_wait == HOLDOFF) begin
            m_mode = 1;
            m_wait = 0;
         end
      end else begin
         n = m_cnt + v;
         if ((n == THRESH && m_tap < TAPS - 1) || (n == -THRESH && m_tap > 0)) begin
            if (n > 0) begin m_sl = 1; m_tap++; end
            else       begin m_sr = 1; m_tap--; end
            m_cnt = 0; m_mode = 2; m_wait = 0; m_quiet = 0; m_lock = 0;
         end else begin
            m_cnt = (n == THRESH || n == -THRESH) ? 0 : n;
            if (m_quiet < LOCK_CNT) m_quiet++;
            m_lock = (m_quiet == LOCK_CNT);
         end
      end
   endfunction

   function logic [8:0] model_pack();
      return {m_sl, m_sr, 4'(m_tap), (m_tap == 0), (m_tap == TAPS - 1), m_lock};
   endfunction

   task automatic cyc(input logic c_en, input logic c_early, input logic c_late);
      logic [8:0] exp;
      @(negedge clk);
      en = c_en;
      early = c_early;
      late = c_late;
      model_edge(c_en, c_early, c_late);
      sbq.push_back(model_pack());
      @(posedge clk);
      #1;
      exp = sbq.pop_front();
      chk("cycle", 32'({sl, sr, tap, amin, amax, lck}), 32'(exp));
      n_sl += int'(sl);
      n_sr += int'(sr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      en = 1'b0; early = 1'b0; late = 1'b0;
      #1;
      chk("reset_vals", 32'({sl, sr, tap, amin, amax, lck}),
          32'({1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0}));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // single left shift: 1 cycle latency then 8 early votes
      repeat (9) cyc(1'b1, 1'b1, 1'b0);
      chk("t1_tap", 32'(tap), 32'd9);
      chk("t1_pulse", 32'(sl), 32'd1);
      chk("t1_nsr", 32'(n_sr), 32'd0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t1_width", 32'(sl), 32'd0);

      // continuous early up to the top tap
      repeat (100) cyc(1'b1, 1'b1, 1'b0);
      chk("t2_tap", 32'(tap), 32'd15);
      chk("t2_atmax", 32'(amax), 32'd1);
      chk("t2_nsl", 32'(n_sl), 32'd7);

      // continuous late from reset down to tap 0
      do_reset();
      n_sl = 0; n_sr = 0;
      repeat (113) cyc(1'b1, 1'b0, 1'b1);
      chk("t3_tap", 32'(tap), 32'd0);
      chk("t3_atmin", 32'(amin), 32'd1);
      chk("t3_nsr", 32'(n_sr), 32'd8);
      chk("t3_nsl", 32'(n_sl), 32'd0);

      // balanced votes reach lock, then 8 early votes break it
      do_reset();
      n_sl = 0; n_sr = 0;
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 70; i++) cyc(1'b1, (i % 2) == 0, (i % 2) == 1);
      chk("t4_locked", 32'(lck), 32'd1);
      chk("t4_nopulse", 32'(n_sl + n_sr), 32'd0);
      repeat (7) cyc(1'b1, 1'b1, 1'b0);
      chk("t4_prelock", 32'(lck), 32'd1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t4_pulse", 32'(sl), 32'd1);
      chk("t4_unlock", 32'(lck), 32'd0);
      chk("t4_tap", 32'(tap), 32'd9);

      // null votes: both set, then neither
      repeat (50) cyc(1'b1, 1'b1, 1'b1);
      repeat (50) cyc(1'b1, 1'b0, 1'b0);
      chk("t5_locked", 32'(lck), 32'd1);
      chk("t5_nsl", 32'(n_sl), 32'd1);
      chk("t5_tap", 32'(tap), 32'd9);

      // reset asserted in the middle of HOLD
      repeat (8) cyc(1'b1, 1'b1, 1'b0);
      chk("t6_pulse", 32'(sl), 32'd1);
      chk("t6_tap", 32'(tap), 32'd10);
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      do_reset();

      // disable after 5 votes discards them
      n_sl = 0; n_sr = 0;
      cyc(1'b1, 1'b0, 1'b0);
      repeat (5) cyc(1'b1, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (7) cyc(1'b1, 1'b1, 1'b0);
      chk("t6_nopulse", 32'(n_sl), 32'd0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t6_lateral", 32'(sl), 32'd1);
      chk("t6_tap2", 32'(tap), 32'd9);

      // mixed random traffic against the model
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
